// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// default data widths.
package uart_tx_arbiter_pkg;

    localparam int NBITS_DEF = 8;
    localparam int NWORD_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage : uart_tx_arbiter_pkg

// File: rtl/uart_tx_arbiter_rr.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the requester that was not granted last time.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       enable,
    output logic       grant_idx,
    output logic [1:0] grant_onehot
);

    always_comb begin
        grant_idx    = 1'b0;
        grant_onehot = '0;
        if (enable) begin
            unique case (valid)
                2'b01:   grant_idx = 1'b0;
                2'b10:   grant_idx = 1'b1;
                2'b11:   grant_idx = ~last_grant;
                default: grant_idx = 1'b0;
            endcase
            if (|valid) begin
                grant_onehot = grant_idx ? 2'b10 : 2'b01;
            end
        end
    end

endmodule : rr_arbiter_2

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two word producers: arbitrates, then
// sends the accepted word LSB byte first through the tx_start/tx_done_tick handshake.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int NWORD = NWORD_DEF
) (
    input  logic             CLK_100MHZ,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [NWORD-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [NWORD-1:0] req1_data,
    output logic             req1_ready,
    input  logic             tx_done_tick,
    output logic             tx_start,
    output logic [NBITS-1:0] data_out,
    output logic             busy,
    output logic             grant
);

    localparam int NBYTES = NWORD / NBITS;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t             state;
    state_t             state_next;
    logic [NWORD-1:0]   shift_reg;
    logic [CNT_W-1:0]   byte_cnt;
    logic               last_grant;
    logic               win_idx;
    logic [1:0]         win_onehot;
    logic               accept;
    logic               last_byte;

    // Gating with reset keeps ready quiet while reset is held in IDLE.
    rr_arbiter_2 u_arb (
        .valid        ({req1_valid, req0_valid}),
        .last_grant   (last_grant),
        .enable       ((state == IDLE) && !reset),
        .grant_idx    (win_idx),
        .grant_onehot (win_onehot)
    );

    assign accept     = |win_onehot;
    assign req0_ready = win_onehot[0];
    assign req1_ready = win_onehot[1];
    assign last_byte  = (byte_cnt == CNT_W'(NBYTES - 1));
    assign tx_start   = (state == SEND);
    assign data_out   = shift_reg[NBITS-1:0];

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = SEND;
            SEND: state_next = WAIT;
            WAIT: if (tx_done_tick) state_next = last_byte ? IDLE : SEND;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_100MHZ) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            byte_cnt   <= '0;
            busy       <= 1'b0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg  <= win_idx ? req1_data : req0_data;
                        grant      <= win_idx;
                        last_grant <= win_idx;
                        byte_cnt   <= '0;
                        busy       <= 1'b1;
                    end
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        if (last_byte) begin
                            busy <= 1'b0;
                        end else begin
                            shift_reg <= shift_reg >> NBITS;
                            byte_cnt  <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte order, round-robin order, waiting
// requesters, stray done ticks and reset in the middle of a word.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        tx_done_tick;
    logic        tx_start;
    logic [7:0]  data_out;
    logic        busy;
    logic        grant;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NBITS(8), .NWORD(32)) dut (
        .CLK_100MHZ   (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .data_out     (data_out),
        .busy         (busy),
        .grant        (grant)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (tx_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Caller has just set the valids; checks who gets ready, then the SEND pulse.
    task automatic accept(input logic w, input string tag);
        logic [1:0] exp_rdy;
        exp_rdy = w ? 2'b10 : 2'b01;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== exp_rdy) begin
            n_err++;
            $display("FAIL %s ready: got %b, required %b", tag, {req1_ready, req0_ready}, exp_rdy);
        end
        step();
        n_cmp++;
        if ({tx_start, busy, grant} !== {2'b11, w}) begin
            n_err++;
            $display("FAIL %s first tx_start/busy/grant: got %b, required %b",
                     tag, {tx_start, busy, grant}, {2'b11, w});
        end
    endtask

    // Plays the uart: done tick 5 cycles after each tx_start, checks each byte.
    task automatic serve_word(input logic g, input logic [31:0] word, input int nb,
                              input bit spur_send, input string tag);
        bit         found;
        logic [7:0] exp;
        for (int b = 0; b < nb; b++) begin
            exp = word[8*b +: 8];
            wait_start(found);
            n_cmp++;
            if (!found) begin
                n_err++;
                $display("FAIL %s tx_start byte %0d: got none in 8 cycles, required pulse", tag, b);
            end
            n_cmp++;
            if (data_out !== exp) begin
                n_err++;
                $display("FAIL %s data byte %0d: got %h, required %h", tag, b, data_out, exp);
            end
            n_cmp++;
            if ({busy, grant, req1_ready, req0_ready} !== {1'b1, g, 2'b00}) begin
                n_err++;
                $display("FAIL %s busy/grant/ready byte %0d: got %b, required %b",
                         tag, b, {busy, grant, req1_ready, req0_ready}, {1'b1, g, 2'b00});
            end
            if (spur_send) tx_done_tick = 1'b1;
            step();
            tx_done_tick = 1'b0;
            n_cmp++;
            if ({tx_start, data_out, req1_ready, req0_ready} !== {1'b0, exp, 2'b00}) begin
                n_err++;
                $display("FAIL %s wait hold byte %0d: got %b, required %b",
                         tag, b, {tx_start, data_out, req1_ready, req0_ready}, {1'b0, exp, 2'b00});
            end
            repeat (4) step();
            tx_done_tick = 1'b1;
            step();
            tx_done_tick = 1'b0;
        end
        if (nb == 4) begin
            n_cmp++;
            if ({busy, tx_start} !== 2'b00) begin
                n_err++;
                $display("FAIL %s end of word busy/tx_start: got %b, required 00", tag, {busy, tx_start});
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        n_cmp++;
        if ({tx_start, data_out, busy, grant, req1_ready, req0_ready} !== 13'b0) begin
            n_err++;
            $display("FAIL reset_init: got %b, required 0", {tx_start, data_out, busy, grant, req1_ready, req0_ready});
        end
        req0_data  = 32'hA5A5_5A5A;
        req0_valid = 1'b1;
        accept(1'b0, "reset_pre");
        req0_valid = 1'b0;
        step();
        step();
        reset      = 1'b1;
        req1_valid = 1'b1;
        step();
        n_cmp++;
        #1;
        if ({tx_start, data_out, busy, req1_ready, req0_ready} !== 12'b0) begin
            n_err++;
            $display("FAIL reset_mid: got %b, required 0", {tx_start, data_out, busy, req1_ready, req0_ready});
        end
        step();
        req1_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_word();
        req0_data  = 32'hDEAD_BEEF;
        req0_valid = 1'b1;
        accept(1'b0, "single");
        req0_valid = 1'b0;
        serve_word(1'b0, 32'hDEAD_BEEF, 4, 1'b0, "single");
    endtask

    task automatic test_round_robin();
        test_reset();
        req0_data  = 32'h1122_3344;
        req1_data  = 32'hAABB_CCDD;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        accept(1'b0, "tie0");
        req0_valid = 1'b0;
        serve_word(1'b0, 32'h1122_3344, 4, 1'b0, "tie0");
        accept(1'b1, "tie1");
        req1_valid = 1'b0;
        serve_word(1'b1, 32'hAABB_CCDD, 4, 1'b0, "tie1");
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        accept(1'b0, "alt0");
        serve_word(1'b0, 32'h1122_3344, 4, 1'b0, "alt0");
        accept(1'b1, "alt1");
        serve_word(1'b1, 32'hAABB_CCDD, 4, 1'b0, "alt1");
        accept(1'b0, "alt2");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        serve_word(1'b0, 32'h1122_3344, 4, 1'b0, "alt2");
    endtask

    task automatic test_wait_while_busy();
        req0_data  = 32'h0BAD_F00D;
        req1_data  = 32'h7654_3210;
        req0_valid = 1'b1;
        accept(1'b0, "busy_req0");
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        serve_word(1'b0, 32'h0BAD_F00D, 4, 1'b0, "busy_req0");
        accept(1'b1, "busy_req1");
        req1_valid = 1'b0;
        serve_word(1'b1, 32'h7654_3210, 4, 1'b0, "busy_req1");
    endtask

    task automatic test_spurious_done();
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        n_cmp++;
        if ({busy, tx_start} !== 2'b00) begin
            n_err++;
            $display("FAIL spurious_idle: got %b, required 00", {busy, tx_start});
        end
        req0_data  = 32'h55AA_33CC;
        req0_valid = 1'b1;
        accept(1'b0, "spurious");
        req0_valid = 1'b0;
        serve_word(1'b0, 32'h55AA_33CC, 4, 1'b1, "spurious");
        begin
            int extra = 0;
            for (int i = 0; i < 6; i++) begin
                if (tx_start === 1'b1) extra++;
                step();
            end
            n_cmp++;
            if (extra != 0) begin
                n_err++;
                $display("FAIL spurious_extra_start: got %0d pulses, required 0", extra);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        bit found;
        int extra = 0;
        req0_data  = 32'h0102_0304;
        req0_valid = 1'b1;
        accept(1'b0, "rst_word");
        req0_valid = 1'b0;
        serve_word(1'b0, 32'h0102_0304, 1, 1'b0, "rst_word");
        wait_start(found);
        n_cmp++;
        if (!found || data_out !== 8'h03) begin
            n_err++;
            $display("FAIL rst_word byte1: got found=%0d data %h, required 1 03", found, data_out);
        end
        repeat (5) step();
        tx_done_tick = 1'b1;
        reset        = 1'b1;
        step();
        tx_done_tick = 1'b0;
        reset        = 1'b0;
        n_cmp++;
        if ({busy, tx_start, data_out} !== 10'b0) begin
            n_err++;
            $display("FAIL rst_word after reset: got %b, required 0", {busy, tx_start, data_out});
        end
        for (int i = 0; i < 6; i++) begin
            if (tx_start === 1'b1) extra++;
            step();
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL rst_word third start: got %0d pulses, required 0", extra);
        end
        req1_data  = 32'hCAFE_F00D;
        req1_valid = 1'b1;
        accept(1'b1, "rst_next");
        req1_valid = 1'b0;
        serve_word(1'b1, 32'hCAFE_F00D, 4, 1'b0, "rst_next");
    endtask

    initial begin
        reset        = 1'b1;
        req0_valid   = 1'b0;
        req1_valid   = 1'b0;
        req0_data    = '0;
        req1_data    = '0;
        tx_done_tick = 1'b0;
        test_reset();
        test_single_word();
        test_round_robin();
        test_wait_while_busy();
        test_spurious_done();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500us, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_tx_arbiter
